// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, flush, funct3,
      output operand_a, operand_b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, funct3,
      input  operand_a, operand_b,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_operand_prep.sv
// Operand sign handling: magnitudes, result sign fixups and the
// RISC-V divide special cases.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] mag_a_o,
   output logic [XLEN-1:0] mag_b_o,
   output logic            neg_res_o,
   output logic            neg_rem_o,
   output logic            div_zero_o,
   output logic            ovf_o
);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic a_sgn, b_sgn;
   logic sa, sb;

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (funct3_i)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         OP_MULHSU: a_sgn = 1'b1;
         default: ;
      endcase
   end

   assign sa = a_sgn & a_i[XLEN-1];
   assign sb = b_sgn & b_i[XLEN-1];

   assign mag_a_o   = sa ? -a_i : a_i;
   assign mag_b_o   = sb ? -b_i : b_i;
   assign neg_res_o = sa ^ sb;
   assign neg_rem_o = sa;

   assign div_zero_o = funct3_i[2] & (b_i == '0);
   // Only the signed divide forms can overflow.
   assign ovf_o = a_sgn & funct3_i[2] &
                  (a_i == MIN_NEG) & (b_i == '1);
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle,
// shift-add multiply and restoring divide on magnitudes.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   state_e state_q, state_d;

   logic [CW-1:0]     cnt_q;
   logic [2:0]        op_q;
   logic              neg_res_q, neg_rem_q;
   logic [XLEN-1:0]   b_q;
   logic [XLEN-1:0]   result_q;
   logic [2*XLEN-1:0] acc_q, acc_d;

   logic [XLEN-1:0] mag_a, mag_b;
   logic            neg_res, neg_rem;
   logic            dz, ovf;

   muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
      .funct3_i   (bus.funct3),
      .a_i        (bus.operand_a),
      .b_i        (bus.operand_b),
      .mag_a_o    (mag_a),
      .mag_b_o    (mag_b),
      .neg_res_o  (neg_res),
      .neg_rem_o  (neg_rem),
      .div_zero_o (dz),
      .ovf_o      (ovf)
   );

   logic special, accept, is_mul;
   logic [XLEN-1:0] spec_val;

   assign special = dz | ovf;
   assign accept  = bus.start & ~bus.flush &
                    (state_q != CALC);
   assign is_mul  = ~op_q[2];
   assign spec_val = bus.funct3[1] ?
                     (dz ? bus.operand_a : '0) :
                     (dz ? '1 : bus.operand_a);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CALC: begin
            if (bus.flush)          state_d = IDLE;
            else if (cnt_q == LAST) state_d = DONE;
         end
         IDLE, DONE: begin
            if (accept) state_d = special ? DONE : CALC;
            else        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy   = (state_q == CALC);
      bus.done   = (state_q == DONE);
      bus.result = result_q;
   end

   // Multiply: acc = {partial, multiplier}; divide: acc = {rem, quotient}.
   logic [XLEN:0]   add, rem_t;
   logic [XLEN-1:0] diff;
   logic            ge;

   always_comb begin
      add   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
              (acc_q[0] ? {1'b0, b_q} : '0);
      rem_t = acc_q[2*XLEN-1:XLEN-1];
      ge    = rem_t >= {1'b0, b_q};
      diff  = rem_t[XLEN-1:0] - b_q;
      if (is_mul)
         acc_d = {add, acc_q[XLEN-1:1]};
      else if (ge)
         acc_d = {diff, acc_q[XLEN-2:0], 1'b1};
      else
         acc_d = {rem_t[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fin;

   always_comb begin
      prod = neg_res_q ? -acc_d : acc_d;
      quo  = neg_res_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
      rem  = neg_rem_q ? -acc_d[2*XLEN-1:XLEN] :
                         acc_d[2*XLEN-1:XLEN];
      unique case (op_q)
         OP_MUL:                       fin = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fin = quo;
         default:                      fin = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         op_q      <= OP_MUL;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_q       <= '0;
         acc_q     <= '0;
         result_q  <= '0;
      end else if (accept) begin
         cnt_q     <= '0;
         op_q      <= bus.funct3;
         neg_res_q <= neg_res;
         neg_rem_q <= neg_rem;
         b_q       <= bus.funct3[2] ? mag_b : mag_a;
         acc_q     <= {{XLEN{1'b0}},
                       bus.funct3[2] ? mag_a : mag_b};
         if (special) result_q <= spec_val;
      end else if (state_q == CALC && !bus.flush) begin
         cnt_q <= cnt_q + 1'b1;
         acc_q <= acc_d;
         if (cnt_q == LAST) result_q <= fin;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner
// sequences and random ops against a plain-arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_if #(.XLEN(32)) bus();

   muldiv_unit #(.XLEN(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib;
      bit ov;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ov) return a;
            return ia / ib;
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (ov) return 32'h0;
            return ia % ib;
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      return f3[2] && (b == 0 || (!f3[0] &&
             a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   task automatic drive(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b);
      bus.funct3    = f3;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
   endtask

   task automatic scramble();
      bus.start     = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      bus.funct3    = 3'($urandom);
   endtask

   // Runs one op; with pre set, start is already high (DONE cycle).
   task automatic run_op(input string name,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp,
                         input bit pre,
                         input bit chain,
                         input logic [2:0] nf3,
                         input logic [31:0] na,
                         input logic [31:0] nb);
      int busy_n, done_at;
      bit spc;
      spc     = is_special(f3, a, b);
      busy_n  = 0;
      done_at = 0;
      if (!pre) drive(f3, a, b);
      for (int n = 1; n <= 40 && done_at == 0; n++) begin
         @(negedge clk);
         if (n == 1) scramble();
         if (bus.busy) busy_n++;
         if (bus.done) begin
            done_at = n;
            check({name, " result"}, bus.result, exp);
            if (chain) drive(nf3, na, nb);
         end
      end
      check({name, " done_cycle"}, 32'(done_at), spc ? 32'd1 : 32'd33);
      check({name, " busy_cycles"}, 32'(busy_n), spc ? 32'd0 : 32'd32);
      if (!chain) begin
         @(negedge clk);
         check({name, " done_pulse"}, {31'b0, bus.done}, 32'd0);
      end
   endtask

   initial begin
      int done_n;
      logic [2:0] f3;
      logic [31:0] a, b;

      reset = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.funct3 = 3'd0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset busy", {31'b0, bus.busy}, 32'd0);
      check("reset done", {31'b0, bus.done}, 32'd0);
      check("reset result", bus.result, 32'd0);

      vecs.push_back('{"MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
      vecs.push_back('{"MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
      vecs.push_back('{"MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{"MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});
      vecs.push_back('{"DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
      vecs.push_back('{"REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
      vecs.push_back('{"DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF});
      vecs.push_back('{"REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5});
      vecs.push_back('{"DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{"REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b,
                vecs[i].exp, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

      // Back-to-back: REMU launched in the DIVU done cycle.
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14,
             1'b0, 1'b1, 3'd7, 32'd100, 32'd7);
      run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2,
             1'b1, 1'b0, 3'd0, 32'd0, 32'd0);

      // Flush at the 10th CALC cycle.
      run_op("MUL pre-flush", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB,
             1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(3'd0, 32'd3, 32'd5);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) scramble();
      end
      check("flush busy before", {31'b0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush busy", {31'b0, bus.busy}, 32'd0);
      check("flush done", {31'b0, bus.done}, 32'd0);
      check("flush result", bus.result, 32'hFFFF_FFEB);
      done_n = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_n++;
      end
      check("flush no done", 32'(done_n), 32'd0);
      check("flush result hold", bus.result, 32'hFFFF_FFEB);

      // start mid-CALC is ignored.
      drive(3'd0, 32'd6, 32'd7);
      done_n = 0;
      for (int n = 1; n <= 40 && done_n == 0; n++) begin
         @(negedge clk);
         if (n == 1) scramble();
         if (n == 5) drive(3'd4, 32'd9, 32'd3);
         if (n == 6) scramble();
         if (bus.done) begin
            done_n = n;
            check("ignored start result", bus.result, 32'd42);
         end
      end
      check("ignored start done_cycle", 32'(done_n), 32'd33);
      @(negedge clk);
      check("ignored start no queue", {31'b0, bus.busy}, 32'd0);

      // Reset in the middle of CALC.
      drive(3'd0, 32'd3, 32'd5);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) scramble();
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset busy", {31'b0, bus.busy}, 32'd0);
      check("midreset done", {31'b0, bus.done}, 32'd0);
      check("midreset result", bus.result, 32'd0);
      run_op("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'd12,
             1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

      // Random ops against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         f3 = 3'($urandom);
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'd0;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b,
                ref_op(f3, a, b), 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
